// File: rtl/fft_frame_ctrl.sv
// Frame sequencer and config controller for the FFT core: regenerates frame tlast from the
// programmed transform length, issues config only at safe frame boundaries and bounds frames in flight.
module fft_frame_ctrl #(
    parameter int                DATA_W       = 64,
    parameter int                CFG_W        = 8,
    parameter logic [CFG_W-1:0]  CFG_RESET    = CFG_W'(8'h01),
    parameter int                MAX_LOG2N    = 16,
    parameter int                MAX_INFLIGHT = 2
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [4:0]        cfg_log2n,
    input  logic [CFG_W-1:0]  cfg_word,
    input  logic              cfg_valid,
    input  logic              err_clear,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              m_axis_data_tvalid,
    input  logic              m_axis_data_tready,
    output logic [DATA_W-1:0] m_axis_data_tdata,
    output logic              m_axis_data_tlast,
    output logic              m_axis_config_tvalid,
    input  logic              m_axis_config_tready,
    output logic [CFG_W-1:0]  m_axis_config_tdata,
    input  logic              s_axis_res_tvalid,
    output logic              s_axis_res_tready,
    input  logic              s_axis_res_tlast,
    output logic              m_axis_res_tvalid,
    input  logic              m_axis_res_tready,
    output logic              m_axis_res_tlast,
    output logic              busy,
    output logic [31:0]       frames_in,
    output logic [31:0]       frames_out,
    output logic              err_tlast_unexpected,
    output logic              err_tlast_missing
);

    localparam int CNT_W = MAX_LOG2N;
    localparam int IF_W  = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONFIG = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    state_t             state_r;
    logic [CFG_W-1:0]   cfg_reg_r;
    logic [CFG_W-1:0]   cfg_out_r;
    logic               cfg_pending_r;
    logic               cfg_fresh_r;
    logic [4:0]         n_log2_r;
    logic [CNT_W-1:0]   beat_cnt_r;
    logic [IF_W-1:0]    inflight_r;
    logic [31:0]        frames_in_r;
    logic [31:0]        frames_out_r;
    logic               err_unexp_r;
    logic               err_miss_r;

    logic [4:0]         log2n_clamp_s;
    logic [CNT_W-1:0]   last_idx_s;
    logic               in_stream_s;
    logic               beat_is_last_s;
    logic               data_fire_s;
    logic               in_end_s;
    logic               out_end_s;
    logic               cfg_fire_s;
    logic               cfg_enter_s;
    logic               stream_enter_s;
    logic               unexp_set_s;
    logic               miss_set_s;

    // Clamp the requested transform length into the supported range.
    always_comb begin
        log2n_clamp_s = cfg_log2n;
        if (cfg_log2n < 5'd3) begin
            log2n_clamp_s = 5'd3;
        end else if (cfg_log2n > 5'(MAX_LOG2N)) begin
            log2n_clamp_s = 5'(MAX_LOG2N);
        end else begin
            log2n_clamp_s = cfg_log2n;
        end
    end

    // Index of the final beat is 2^n - 1, i.e. the low n bits set.
    assign last_idx_s     = {CNT_W{1'b1}} >> (5'(MAX_LOG2N) - n_log2_r);
    assign in_stream_s    = (state_r == ST_STREAM);
    assign beat_is_last_s = (beat_cnt_r == last_idx_s);
    assign data_fire_s    = in_stream_s & s_axis_tvalid & m_axis_data_tready;
    assign in_end_s       = data_fire_s & beat_is_last_s;
    assign out_end_s      = s_axis_res_tvalid & m_axis_res_tready & s_axis_res_tlast;
    assign cfg_fire_s     = (state_r == ST_CONFIG) & m_axis_config_tready;
    assign cfg_enter_s    = (state_r == ST_IDLE) & cfg_pending_r & (inflight_r == IF_W'(0));
    assign stream_enter_s = (state_r == ST_IDLE) & ~cfg_enter_s & s_axis_tvalid & ~cfg_pending_r
                            & (inflight_r < IF_W'(MAX_INFLIGHT));
    assign unexp_set_s    = data_fire_s & s_axis_tlast & ~beat_is_last_s;
    assign miss_set_s     = data_fire_s & beat_is_last_s & ~s_axis_tlast;

    assign s_axis_tready        = in_stream_s & m_axis_data_tready;
    assign m_axis_data_tvalid   = in_stream_s & s_axis_tvalid;
    assign m_axis_data_tdata    = s_axis_tdata;
    assign m_axis_data_tlast    = in_stream_s & beat_is_last_s;
    assign m_axis_config_tvalid = (state_r == ST_CONFIG);
    assign m_axis_config_tdata  = cfg_out_r;
    assign m_axis_res_tvalid    = s_axis_res_tvalid;
    assign s_axis_res_tready    = m_axis_res_tready;
    assign m_axis_res_tlast     = s_axis_res_tlast;
    assign busy                 = (state_r != ST_IDLE) | (inflight_r != IF_W'(0));
    assign frames_in            = frames_in_r;
    assign frames_out           = frames_out_r;
    assign err_tlast_unexpected = err_unexp_r;
    assign err_tlast_missing    = err_miss_r;

    // Frame sequencer: the issued config word is frozen on CONFIG entry so it is stable until accepted.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r    <= ST_IDLE;
            cfg_out_r  <= CFG_RESET;
            n_log2_r   <= 5'd3;
            beat_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cfg_enter_s) begin
                        state_r   <= ST_CONFIG;
                        cfg_out_r <= cfg_reg_r;
                    end else if (stream_enter_s) begin
                        state_r    <= ST_STREAM;
                        n_log2_r   <= log2n_clamp_s;
                        beat_cnt_r <= '0;
                    end
                end
                ST_CONFIG: begin
                    if (m_axis_config_tready) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (data_fire_s) begin
                        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                        if (beat_is_last_s) begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Config request capture; a word arriving while CONFIG is already presenting keeps the request alive.
    always_ff @(posedge aclk) begin
        if (areset) begin
            cfg_reg_r     <= CFG_RESET;
            cfg_pending_r <= 1'b1;
            cfg_fresh_r   <= 1'b0;
        end else begin
            if (cfg_valid) begin
                cfg_reg_r     <= cfg_word;
                cfg_pending_r <= 1'b1;
                cfg_fresh_r   <= 1'b1;
            end else begin
                if (cfg_enter_s) begin
                    cfg_fresh_r <= 1'b0;
                end
                if (cfg_fire_s && !cfg_fresh_r) begin
                    cfg_pending_r <= 1'b0;
                end
            end
        end
    end

    // Frame counters, in-flight accounting and sticky framing errors.
    always_ff @(posedge aclk) begin
        if (areset) begin
            inflight_r   <= '0;
            frames_in_r  <= 32'd0;
            frames_out_r <= 32'd0;
            err_unexp_r  <= 1'b0;
            err_miss_r   <= 1'b0;
        end else begin
            if (in_end_s) begin
                frames_in_r <= frames_in_r + 32'd1;
            end
            if (out_end_s) begin
                frames_out_r <= frames_out_r + 32'd1;
            end
            if (in_end_s && !out_end_s) begin
                inflight_r <= inflight_r + IF_W'(1);
            end else if (out_end_s && !in_end_s && (inflight_r != IF_W'(0))) begin
                inflight_r <= inflight_r - IF_W'(1);
            end
            if (unexp_set_s) begin
                err_unexp_r <= 1'b1;
            end else if (err_clear) begin
                err_unexp_r <= 1'b0;
            end
            if (miss_set_s) begin
                err_miss_r <= 1'b1;
            end else if (err_clear) begin
                err_miss_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed self-checking bench for fft_frame_ctrl: reset config, framing, errors,
// in-flight limiting, deferred config and coincident frame ends.
module tb_fft_frame_ctrl;

    localparam int DATA_W = 64;
    localparam int CFG_W  = 8;

    logic              aclk = 1'b0;
    logic              areset;
    logic [4:0]        cfg_log2n;
    logic [CFG_W-1:0]  cfg_word;
    logic              cfg_valid;
    logic              err_clear;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DATA_W-1:0] s_axis_tdata;
    logic              s_axis_tlast;
    logic              m_axis_data_tvalid;
    logic              m_axis_data_tready;
    logic [DATA_W-1:0] m_axis_data_tdata;
    logic              m_axis_data_tlast;
    logic              m_axis_config_tvalid;
    logic              m_axis_config_tready;
    logic [CFG_W-1:0]  m_axis_config_tdata;
    logic              s_axis_res_tvalid;
    logic              s_axis_res_tready;
    logic              s_axis_res_tlast;
    logic              m_axis_res_tvalid;
    logic              m_axis_res_tready;
    logic              m_axis_res_tlast;
    logic              busy;
    logic [31:0]       frames_in;
    logic [31:0]       frames_out;
    logic              err_tlast_unexpected;
    logic              err_tlast_missing;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cfg_beats = 0;
    int cfg_cyc   = 0;
    logic [CFG_W-1:0] cfg_last = '0;
    logic tog_en = 1'b0;

    fft_frame_ctrl dut (
        .aclk(aclk), .areset(areset),
        .cfg_log2n(cfg_log2n), .cfg_word(cfg_word), .cfg_valid(cfg_valid), .err_clear(err_clear),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .m_axis_data_tvalid(m_axis_data_tvalid), .m_axis_data_tready(m_axis_data_tready),
        .m_axis_data_tdata(m_axis_data_tdata), .m_axis_data_tlast(m_axis_data_tlast),
        .m_axis_config_tvalid(m_axis_config_tvalid), .m_axis_config_tready(m_axis_config_tready),
        .m_axis_config_tdata(m_axis_config_tdata),
        .s_axis_res_tvalid(s_axis_res_tvalid), .s_axis_res_tready(s_axis_res_tready),
        .s_axis_res_tlast(s_axis_res_tlast),
        .m_axis_res_tvalid(m_axis_res_tvalid), .m_axis_res_tready(m_axis_res_tready),
        .m_axis_res_tlast(m_axis_res_tlast),
        .busy(busy), .frames_in(frames_in), .frames_out(frames_out),
        .err_tlast_unexpected(err_tlast_unexpected), .err_tlast_missing(err_tlast_missing)
    );

    always #5 aclk = ~aclk;

    // Cycle index, read at negedge as the number of the current cycle.
    always @(posedge aclk) cyc <= cyc + 1;

    // Config channel monitor.
    always @(posedge aclk) begin
        if (!areset && m_axis_config_tvalid && m_axis_config_tready) begin
            cfg_beats <= cfg_beats + 1;
            cfg_last  <= m_axis_config_tdata;
            cfg_cyc   <= cyc;
        end
    end

    // Downstream data ready: held high, or toggled every cycle when enabled.
    initial begin
        m_axis_data_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            if (tog_en) m_axis_data_tready = ~m_axis_data_tready;
            else        m_axis_data_tready = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Send one frame of nb beats; tl_mask gives upstream tlast per beat. Returns the output tlast
    // pattern and the cycle numbers of the first and last accepted beats.
    task automatic send_frame(input int nb, input logic [15:0] tl_mask, input int cfg_at,
                              input logic res_at_end, output logic [15:0] out_mask,
                              output int first_cyc, output int last_cyc);
        logic got;
        out_mask  = 16'h0000;
        first_cyc = 0;
        last_cyc  = 0;
        for (int b = 0; b < nb; b++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = tl_mask[b];
            s_axis_tdata  = {32'hFEED_F00D, 32'hC0DE_0000 + 32'(b)};
            if (b == cfg_at) begin
                cfg_valid = 1'b1;
                cfg_word  = 8'h00;
            end
            got = 1'b0;
            for (int w = 0; w < 64 && !got; w++) begin
                @(negedge aclk);
                if (s_axis_tready) begin
                    got = 1'b1;
                    out_mask[b] = m_axis_data_tlast;
                    if (b == 0) begin
                        first_cyc = cyc;
                        check_eq("data_pass", m_axis_data_tdata[31:0], 32'hC0DE_0000);
                    end
                    if (b == nb - 1) begin
                        last_cyc = cyc;
                        if (res_at_end) begin
                            s_axis_res_tvalid = 1'b1;
                            s_axis_res_tlast  = 1'b1;
                        end
                    end
                end
                @(posedge aclk);
                #1;
                cfg_valid = 1'b0;
                s_axis_res_tvalid = 1'b0;
                s_axis_res_tlast  = 1'b0;
            end
            if (!got) check_eq("beat_timeout", 32'(got), 32'd1);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // One result beat with tlast, accepted on the next edge.
    task automatic push_res();
        s_axis_res_tvalid = 1'b1;
        s_axis_res_tlast  = 1'b1;
        @(negedge aclk);
        check_eq("res_pass", {30'd0, m_axis_res_tvalid, m_axis_res_tlast}, 32'd3);
        @(posedge aclk);
        #1;
        s_axis_res_tvalid = 1'b0;
        s_axis_res_tlast  = 1'b0;
    endtask

    initial begin
        logic [15:0] om;
        int f1, l1, f2, l2, r, vcnt, nbeat, rdy, cfgv;
        logic data_ok;

        areset = 1'b1; cfg_log2n = 5'd3; cfg_word = 8'h00; cfg_valid = 1'b0; err_clear = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
        m_axis_config_tready = 1'b0; s_axis_res_tvalid = 1'b0; s_axis_res_tlast = 1'b0;
        m_axis_res_tready = 1'b1;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_eq("rst_outputs", {28'd0, m_axis_config_tvalid, m_axis_data_tvalid, s_axis_tready, busy}, 32'd0);
        check_eq("rst_frames_in", frames_in, 32'd0);
        check_eq("rst_frames_out", frames_out, 32'd0);
        check_eq("rst_errors", {30'd0, err_tlast_unexpected, err_tlast_missing}, 32'd0);
        @(posedge aclk);
        #1;
        areset = 1'b0;

        // Reset config word with the config channel stalled for 5 cycles
        @(negedge aclk);
        check_eq("cfg_first_cycle", 32'(m_axis_config_tvalid), 32'd0);
        vcnt = 0; nbeat = 0; data_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge aclk);
            if (m_axis_config_tvalid) begin
                vcnt++;
                if (m_axis_config_tdata != 8'h01) data_ok = 1'b0;
            end
            m_axis_config_tready = (vcnt >= 6);
            if (m_axis_config_tvalid && m_axis_config_tready) nbeat++;
        end
        check_eq("cfg_valid_cycles", 32'(vcnt), 32'd6);
        check_eq("cfg_beat_count", 32'(nbeat), 32'd1);
        check_eq("cfg_data_stable", 32'(data_ok), 32'd1);
        check_eq("cfg_busy_after", 32'(busy), 32'd0);
        @(posedge aclk);
        #1;
        check_eq("cfg_mon_word", 32'(cfg_last), 32'h01);

        // Two back-to-back 8-beat frames
        send_frame(8, 16'h0080, -1, 1'b0, om, f1, l1);
        check_eq("t2_tlast_f1", 32'(om), 32'h0080);
        send_frame(8, 16'h0080, -1, 1'b0, om, f2, l2);
        check_eq("t2_tlast_f2", 32'(om), 32'h0080);
        check_eq("t2_bubble", 32'(f2 - l1), 32'd2);
        check_eq("t2_frames_in", frames_in, 32'd2);
        check_eq("t2_errors", {30'd0, err_tlast_unexpected, err_tlast_missing}, 32'd0);
        check_eq("t2_busy", 32'(busy), 32'd1);
        push_res();
        push_res();
        check_eq("t2_frames_out", frames_out, 32'd2);
        check_eq("t2_idle", 32'(busy), 32'd0);

        // Early upstream tlast on beat 5, none on beat 7
        send_frame(8, 16'h0020, -1, 1'b0, om, f1, l1);
        check_eq("t3_tlast", 32'(om), 32'h0080);
        check_eq("t3_errors", {30'd0, err_tlast_unexpected, err_tlast_missing}, 32'd3);
        err_clear = 1'b1;
        @(posedge aclk);
        #1;
        err_clear = 1'b0;
        check_eq("t3_err_clear", {30'd0, err_tlast_unexpected, err_tlast_missing}, 32'd0);
        check_eq("t3_frames_in", frames_in, 32'd3);
        push_res();

        // In-flight limit: third frame blocked until one result frame completes
        send_frame(8, 16'h0080, -1, 1'b0, om, f1, l1);
        send_frame(8, 16'h0080, -1, 1'b0, om, f2, l2);
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        rdy = 0;
        repeat (5) begin
            @(negedge aclk);
            if (s_axis_tready) rdy++;
        end
        @(posedge aclk);
        #1;
        check_eq("t4_blocked", 32'(rdy), 32'd0);
        s_axis_res_tvalid = 1'b1;
        s_axis_res_tlast  = 1'b1;
        @(negedge aclk);
        r = cyc;
        @(posedge aclk);
        #1;
        s_axis_res_tvalid = 1'b0;
        s_axis_res_tlast  = 1'b0;
        send_frame(8, 16'h0080, -1, 1'b0, om, f1, l1);
        check_eq("t4_restart_delay", 32'(f1 - r), 32'd2);
        check_eq("t4_tlast", 32'(om), 32'h0080);
        check_eq("t4_frames_out", frames_out, 32'd4);
        push_res();
        push_res();
        check_eq("t4_idle", 32'(busy), 32'd0);

        // Config request mid-frame with one frame already in flight
        send_frame(8, 16'h0080, -1, 1'b0, om, f1, l1);
        send_frame(8, 16'h0080, 3, 1'b0, om, f1, l1);
        check_eq("t5_tlast", 32'(om), 32'h0080);
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        rdy = 0; cfgv = 0;
        repeat (4) begin
            @(negedge aclk);
            if (s_axis_tready) rdy++;
            if (m_axis_config_tvalid) cfgv++;
        end
        @(posedge aclk);
        #1;
        check_eq("t5_no_stream", 32'(rdy), 32'd0);
        check_eq("t5_cfg_deferred", 32'(cfgv), 32'd0);
        check_eq("t5_cfg_beats_before", 32'(cfg_beats), 32'd1);
        cfg_log2n = 5'd4;
        push_res();
        push_res();
        send_frame(16, 16'h8000, -1, 1'b0, om, f1, l1);
        check_eq("t5_tlast_n16", 32'(om), 32'h8000);
        check_eq("t5_cfg_beats_after", 32'(cfg_beats), 32'd2);
        check_eq("t5_cfg_word", 32'(cfg_last), 32'h00);
        check_eq("t5_cfg_before_frame", 32'(f1 - cfg_cyc), 32'd2);
        push_res();
        check_eq("t5_frames", {frames_in[15:0], frames_out[15:0]}, {16'd9, 16'd9});

        // Toggling data ready; input frame end coincides with a result tlast
        cfg_log2n = 5'd0;
        send_frame(8, 16'h0080, -1, 1'b0, om, f1, l1);
        tog_en = 1'b1;
        send_frame(8, 16'h0080, -1, 1'b1, om, f2, l2);
        tog_en = 1'b0;
        check_eq("t6_tlast_clamped", 32'(om), 32'h0080);
        check_eq("t6_frames_in", frames_in, 32'd11);
        check_eq("t6_frames_out", frames_out, 32'd10);
        check_eq("t6_inflight_kept", 32'(busy), 32'd1);
        push_res();
        check_eq("t6_drained", 32'(busy), 32'd0);
        check_eq("t6_frames_out_final", frames_out, 32'd11);
        check_eq("t6_errors", {30'd0, err_tlast_unexpected, err_tlast_missing}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
# fft_frame_ctrl

Frame sequencer and configuration controller for the 1D FFT datapath. It sits between the 512→64 input width converter and the FFT core's data and config channels, and taps the core's result stream before the 64→512 output converter. It regenerates frame tlast from a programmable transform length and issues config transactions only at safe frame boundaries. It also limits the number of frames in flight inside the core and reports framing errors and frame counters.

## Interface
Parameters:
- DATA_W, 64, sample width on data and result channels
- CFG_W, 8, FFT config word width
- CFG_RESET, 8'h01, config word issued automatically after reset
- MAX_LOG2N, 16, largest supported log2 transform length (minimum is fixed at 3)
- MAX_INFLIGHT, 2, maximum frames accepted by the core but not yet fully output

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- cfg_log2n  in  5  log2 transform length; sampled on the IDLE→STREAM transition
- cfg_word  in  CFG_W  config word to send to the core
- cfg_valid  in  1  one-cycle request to send cfg_word
- err_clear  in  1  clears the sticky error flags
- s_axis_tvalid / s_axis_tready / s_axis_tdata[DATA_W] / s_axis_tlast  in/out/in/in  upstream samples
- m_axis_data_tvalid / m_axis_data_tready / m_axis_data_tdata[DATA_W] / m_axis_data_tlast  out/in/out/out  core data input
- m_axis_config_tvalid / m_axis_config_tready / m_axis_config_tdata[CFG_W]  out/in/out  core config
- s_axis_res_tvalid / s_axis_res_tready / s_axis_res_tlast  in/out/in  core result tap
- m_axis_res_tvalid / m_axis_res_tready / m_axis_res_tlast  out/in/out  result to downstream; tdata is not routed through this block
- busy  out  1  state is not IDLE, or inflight is not 0
- frames_in  out  32  input frames completed
- frames_out  out  32  result frames completed
- err_tlast_unexpected  out  1  sticky error flag
- err_tlast_missing  out  1  sticky error flag

## Operation
- States: IDLE, CONFIG, STREAM.
- IDLE transitions:
  - Go to CONFIG when cfg_pending=1 and inflight=0. CONFIG has priority over STREAM.
  - Otherwise go to STREAM when s_axis_tvalid=1, cfg_pending=0 and inflight<MAX_INFLIGHT. On this transition, latch n_log2 = clamp(cfg_log2n, 3, MAX_LOG2N) and set beat_cnt=0.
- CONFIG:
  - m_axis_config_tvalid=1 and m_axis_config_tdata=cfg_reg.
  - Hold until m_axis_config_tready; on the handshake, go to IDLE.
- STREAM:
  - Combinational passthrough: m_axis_data_tvalid=s_axis_tvalid, s_axis_tready=m_axis_data_tready, tdata passed through.
  - m_axis_data_tlast = (beat_cnt == 2^n_log2 − 1).
  - beat_cnt increments on each accepted beat.
  - On the accepted last beat: go to IDLE, increment frames_in and increment inflight.
- In IDLE and CONFIG: s_axis_tready=0 and m_axis_data_tvalid=0.
- Config request handling:
  - On cfg_valid: cfg_reg←cfg_word and cfg_pending←1. If a request is already pending, the latest word wins.
  - cfg_pending clears on the config handshake, unless cfg_valid is asserted in the same cycle; then it stays 1 with the new word.
  - A request made mid-frame is deferred to the frame end, and further until inflight=0.
- Upstream tlast checking (does not alter output framing):
  - On an accepted beat with s_axis_tlast=1 and beat_cnt ≠ N−1: set err_tlast_unexpected.
  - On the accepted beat at beat_cnt=N−1 with s_axis_tlast=0: set err_tlast_missing.
  - err_clear clears both flags. An error set in the same cycle as err_clear wins.
- Result path (always combinational):
  - m_axis_res_tvalid=s_axis_res_tvalid, s_axis_res_tready=m_axis_res_tready, tlast passed through.
  - An accepted result beat with tlast: increment frames_out and decrement inflight.
- inflight counter:
  - Width is clog2(MAX_INFLIGHT+1).
  - If an input frame end and an output frame end occur in the same cycle, inflight is unchanged.
  - A result tlast while inflight=0 does not decrement; frames_out still increments.
- frames_in and frames_out wrap modulo 2^32.

## Timing
- Reset values: state=IDLE, cfg_pending=1, cfg_reg=CFG_RESET, inflight=0, beat_cnt=0, frames_in=0, frames_out=0, both error flags=0.
- Outputs during reset: m_axis_config_tvalid=0, m_axis_data_tvalid=0, s_axis_tready=0, busy=0.
- First cycle after reset release: CONFIG is entered on the following edge, so the CFG_RESET beat is presented on cycle 2.
- Data path latency is 0 cycles (passthrough). State transitions take 1 cycle.
- IDLE→STREAM costs one bubble: the first beat is accepted no earlier than the cycle after IDLE.
- There is at least one IDLE cycle between consecutive frames.
- While m_axis_config_tvalid is asserted, it stays stable until tready. Config tdata does not change during CONFIG.
- Reset mid-frame abandons the partial frame with no recovery beat. The FFT core must be reset together with this block.

## Test plan
- Reset release with m_axis_config_tready held low for 5 cycles → exactly one config beat 8'h01, tvalid held for 6 cycles, then IDLE; busy deasserts.
- cfg_log2n=3, 16 continuous beats with upstream tlast on beats 7 and 15 → m_axis_data_tlast on beats 7 and 15, one bubble between frames, frames_in=2, no errors.
- cfg_log2n=3, upstream tlast on beat 5 and none on beat 7 → err_tlast_unexpected=1 and err_tlast_missing=1, output tlast still on beat 7; err_clear → both flags 0.
- MAX_INFLIGHT=2, result path stalled, three frames offered → third frame blocked (s_axis_tready=0); one result tlast is accepted → third frame starts one cycle later.
- cfg_valid with 8'h00 at beat 3 of a frame, with one prior frame in flight → no config beat until frame end and until frames_out catches up; then exactly one beat 8'h00 before the next frame.
- m_axis_data_tready toggling every cycle, with an input frame end coinciding with a result tlast → beat count correct, inflight unchanged, frames_in and frames_out both increment.
